// File: rtl/rr_arb_pkg.sv
// Shared types, sizes and the rotating-priority helper for the 8-way round-robin arbiter.
package rr_arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    // First set request scanning ptr, ptr+1, ... with modulo-8 wrap.
    function automatic logic [IDX_W-1:0] next_owner(input logic [N_REQ-1:0] req,
                                                     input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] cand;
        logic             found;
        idx   = ptr;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ptr + IDX_W'(k);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_8_dec.sv
// Combinational 3-to-8 one-hot decode of the registered grant index, gated by the grant enable.
module gnt_onehot_dec
    import rr_arb_pkg::*;
(
    input  logic [IDX_W-1:0] idx_i,
    input  logic             en_i,
    output logic [N_REQ-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            onehot_o[i] = en_i && (idx_i == IDX_W'(i));
        end
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for eight requesters with hold-until-release grants and a one-cycle turnaround.
// Optional hold-time limit enabled by defining RR_ARB_TIMEOUT_EN (limit set by MAX_HOLD).
module rr_arbiter_8
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arbiter_8: MAX_HOLD must be in 2..255");
    end

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             vld_q, vld_d;
    logic             owner_rel;
    logic             hold_exp;

`ifdef RR_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;

    assign hold_exp = (cnt_q == HOLD_LAST);
    assign timeout  = timeout_q;
`else
    assign hold_exp = 1'b0;
    assign timeout  = 1'b0;
`endif

    // done and a withdrawn owner request in the same cycle are one release.
    assign owner_rel = done || !req[idx_q];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
`ifdef RR_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    idx_d   = next_owner(req, ptr_q);
                    vld_d   = 1'b1;
                    state_d = GRANT;
`ifdef RR_ARB_TIMEOUT_EN
                    cnt_d   = 8'd0;
`endif
                end
            end
            GRANT: begin
                if (owner_rel || hold_exp) begin
                    state_d = GAP;
                    vld_d   = 1'b0;
                    ptr_d   = idx_q + 1'b1;
                end
`ifdef RR_ARB_TIMEOUT_EN
                timeout_d = hold_exp && !owner_rel;
                if (!(owner_rel || hold_exp)) begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
`endif

    assign gnt_valid = vld_q;
    assign gnt_idx   = idx_q;

    gnt_onehot_dec u_dec (
        .idx_i    (idx_q),
        .en_i     (vld_q),
        .onehot_o (gnt)
    );

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed and randomized bench for rr_arbiter_8 against a cycle-level behavioural model.
module tb_rr_arbiter_8;

    localparam int MAX_HOLD = 4;
`ifdef RR_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    rr_arbiter_8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: owner index (-1 = none), turnaround flag, priority pointer, cycles held, timeout pulse.
    int m_owner = -1;
    bit m_gap   = 1'b0;
    int m_ptr   = 0;
    int m_hold  = 0;
    bit m_tout  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_gap   = 1'b0;
        m_ptr   = 0;
        m_hold  = 0;
        m_tout  = 1'b0;
    endtask

    task automatic model_step();
        bit rel;
        bit exp_lim;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_tout = 1'b0;
        if (m_owner >= 0) begin
            rel     = done || !req[m_owner];
            exp_lim = TO_EN && (m_hold == MAX_HOLD - 1);
            if (rel || exp_lim) begin
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
                m_gap   = 1'b1;
                m_tout  = exp_lim && !rel;
            end else begin
                m_hold++;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (req != 8'h00) begin
            for (int k = 0; k < 8; k++) begin
                if (m_owner < 0 && req[(m_ptr + k) % 8]) m_owner = (m_ptr + k) % 8;
            end
            m_hold = 0;
        end
    endtask

    task automatic check_outputs();
        check("gnt", 32'(gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        check("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
        check("timeout", 32'(timeout), 32'(m_tout));
        if (m_owner >= 0) check("gnt_idx", 32'(gnt_idx), 32'(m_owner));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic async_reset_pulse();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        tick();
        rst_n = 1'b1;
    endtask

    int      seq[$];
    bit      prev_v;
    int      run_len;
    int      tout_cnt;
    bit      run_open;

    initial begin
        // Reset state
        #1;
        check_outputs();
        tick();
        rst_n = 1'b1;

        // Reset mid-grant, then ptr must be back at 0
        req = 8'h10;
        tick();
        tick();
        check("midgrant_gnt", 32'(gnt), 32'h10);
        async_reset_pulse();
        check("reset_gnt_zero", 32'(gnt), 32'h0);
        req = 8'h01;
        tick();
        check("after_reset_idx", 32'(gnt_idx), 32'd0);
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 8'h00;
        tick();
        tick();

        // Single requester: exactly three grant cycles, one dead cycle, regrant two after done
        req = 8'h04;
        run_len = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (gnt == 8'h04) run_len++;
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        check("single_width", 32'(run_len), 32'd3);
        check("single_gap", 32'(gnt), 32'h0);
        tick();
        tick();
        check("single_regrant", 32'(gnt), 32'h04);
        req = 8'h00;
        tick();
        tick();
        tick();

        // Rotation with wrap 7 -> 0, done held high (also a done in IDLE)
        async_reset_pulse();
        req    = 8'hFF;
        done   = 1'b1;
        prev_v = 1'b0;
        for (int i = 0; i < 27; i++) begin
            tick();
            if (gnt_valid && !prev_v) seq.push_back(int'(gnt_idx));
            prev_v = gnt_valid;
        end
        check("rot_count", 32'(seq.size()), 32'd9);
        for (int i = 0; i < seq.size() && i < 9; i++) check("rot_order", 32'(seq[i]), 32'(i % 8));
        done = 1'b0;
        req  = 8'h00;
        tick();
        tick();
        tick();

        // Pointer skip: after owner 5 releases, 8'h21 scans 6,7,0
        req = 8'h20;
        tick();
        check("skip_owner5", 32'(gnt_idx), 32'd5);
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 8'h21;
        tick();
        tick();
        check("skip_next_idx", 32'(gnt_idx), 32'd0);
        req = 8'h00;
        tick();
        tick();
        tick();

        // Owner withdrawal, then simultaneous done + withdrawal, then done in IDLE
        req = 8'h08;
        tick();
        tick();
        req = 8'h00;
        tick();
        check("withdraw_release", 32'(gnt_valid), 32'd0);
        tick();
        req = 8'h10;
        tick();
        done = 1'b1;
        req  = 8'h00;
        tick();
        done = 1'b0;
        req  = 8'hFF;
        tick();
        tick();
        check("single_advance", 32'(gnt_idx), 32'd5);
        req = 8'h00;
        tick();
        tick();
        tick();
        done = 1'b1;
        tick();
        tick();
        check("done_idle", 32'(gnt_valid), 32'd0);
        done = 1'b0;

        // Hold limit: req=8'h02 with no done
        req      = 8'h02;
        run_len  = 0;
        run_open = 1'b1;
        tout_cnt = 0;
        for (int i = 0; i < 110; i++) begin
            tick();
            if (timeout) tout_cnt++;
            if (run_open && gnt == 8'h02) run_len++;
            else if (run_len > 0) run_open = 1'b0;
        end
        if (TO_EN) begin
            check("hold_len", 32'(run_len), 32'(MAX_HOLD));
            check("tout_seen", 32'(tout_cnt > 0), 32'd1);
        end else begin
            check("hold_len", 32'(run_len), 32'd110);
            check("tout_seen", 32'(tout_cnt), 32'd0);
        end
        req = 8'h00;
        tick();
        tick();
        tick();
        req = 8'h05;
        tick();
        check("ptr_after_hold", 32'(gnt_idx), 32'd2);
        req = 8'h00;
        tick();
        tick();
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req = 8'($urandom);
            done = ($urandom_range(0, 3) == 0);
            if (i == 200) async_reset_pulse();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
